reg_rename_file: RTL
====================

// Module: reg_rename_file
// PURPOSE
//   Architectural register file with per-register rename tags; receiving end of the ROB commit port and
//   the ROB-tag producer for the dispatcher. Dispatch renames rd to its ROB id; commit writes the value
//   and clears the tag if still owned; a committed mispredict clears all tags. Sits between ROB and dispatcher.
// PARAMETERS
//   REG_NUM      32  architectural registers; x0 hardwired to zero, never renamed
//   REG_POS_W    5   register index width (log2 REG_NUM)
//   ROB_ID_W     5   ROB tag width; tag = ROB index + 1, tag 0 = "value is in register"
//   DATA_W       32  register data width
// PORTS
//   clk                 in   1          clock, rising edge
//   rst                 in   1          synchronous reset, active high
//   rs1_from_dsp        in   REG_POS_W  source register 1 read index
//   rs2_from_dsp        in   REG_POS_W  source register 2 read index
//   Q1_to_dsp           out  ROB_ID_W   rs1 pending ROB tag (0 = V1 valid)
//   Q2_to_dsp           out  ROB_ID_W   rs2 pending ROB tag (0 = V2 valid)
//   V1_to_dsp           out  DATA_W     rs1 value (meaningful when Q1 = 0)
//   V2_to_dsp           out  DATA_W     rs2 value (meaningful when Q2 = 0)
//   ena_from_dsp        in   1          rename request this cycle
//   rd_from_dsp         in   REG_POS_W  destination register to rename
//   rob_id_from_dsp     in   ROB_ID_W   ROB tag allocated to that instruction
//   commit_flag         in   1          ROB commits an entry this cycle
//   rd_from_rob         in   REG_POS_W  committed destination
//   Q_from_rob          in   ROB_ID_W   committed entry's tag
//   V_from_rob          in   DATA_W     committed value
//   commit_jump_flag    in   1          committed entry mispredicted: flush all speculative tags
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all values and tags <= 0; reads then return Q=0, V=0. Reset wins over all.
//   - Read (combinational, 0-cycle): rs=0 -> Q=0,V=0. Else if commit_flag & rd_from_rob==rs & tag[rs]==Q_from_rob
//     -> bypass: Q=0, V=V_from_rob. Else Q=tag[rs], V=value[rs]. Same-cycle rename is NOT visible to reads.
//   - Commit (posedge, commit_flag=1, rd_from_rob!=0): value[rd] <= V_from_rob always; tag[rd] <= 0 only if
//     tag[rd]==Q_from_rob (a younger rename keeps ownership).
//   - Rename (posedge, ena_from_dsp=1, rd_from_dsp!=0, no flush): tag[rd] <= rob_id_from_dsp.
//   - Commit and rename same rd same cycle: rename wins the tag; commit still writes value.
//   - Flush (commit_jump_flag=1): all tags <= 0; any same-cycle commit value write still applies (jal/jalr rd);
//     same-cycle rename ignored (wrong path). Flush with commit_flag=0 only clears tags.
//   - Writes/renames to x0 ignored; value[0] and tag[0] stay 0.
//   - Tag 0 is never a valid rename id; rob_id_from_dsp=0 with ena=1 is illegal (assertion in sim).
//   - No stalls, no handshake: every request is accepted in the cycle it is presented.
// STRUCTURE
//   - Shared defines: REG_POS_TYPE, ROB_ID_TYPE, DATA_TYPE, ZERO_ROB, ZERO_REG, ZERO_WORD, TRUE/FALSE.
//   - One sub-module: reg_rename_read_port (rs index + commit bus + arrays -> Q,V incl. bypass), instanced x2.
//   - Storage: value[REG_NUM], tag[REG_NUM]; single always @(posedge clk) block for reset/commit/flush/rename.
// TESTING
//   1 Reset then read rs1=5,rs2=0 -> Q1=0,V1=0,Q2=0,V2=0.
//   2 Rename x3->tag 4; next cycle read x3 -> Q=4; commit rd=3,Q=4,V=0x55 -> same cycle Q=0,V=0x55; after: tag 0.
//   3 Rename x3->4, then x3->7; commit rd=3,Q=4,V=0x11 -> value=0x11 but read x3 still Q=7.
//   4 Same cycle commit rd=6,Q=2,V=9 (tag[6]=2) and rename x6->8 -> tag[6]=8, value[6]=9.
//   5 Tags x1=2,x2=3; commit rd=1,Q=2,V=0x100 with commit_jump_flag=1 and rename x4->5 -> all tags 0,
//     value[1]=0x100, x4 not renamed.
//   6 Rename x0->3, commit rd=0,V=0xFF -> read x0 gives Q=0,V=0; rst mid-sequence clears all state.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared widths, types and constants for the rename-tagged architectural register file.
package reg_rename_file_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_POS_W = 5;
  localparam int ROB_ID_W  = 5;
  localparam int DATA_W    = 32;

  typedef logic [REG_POS_W-1:0] reg_pos_type;
  typedef logic [ROB_ID_W-1:0]  rob_id_type;
  typedef logic [DATA_W-1:0]    data_type;

  // Tag 0 means "the value is in the register"; ROB tags are ROB index + 1.
  localparam rob_id_type  ZERO_ROB  = '0;
  localparam reg_pos_type ZERO_REG  = '0;
  localparam data_type    ZERO_WORD = '0;
  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;

endpackage

// File: rtl/reg_rename_read_port.sv
// One dispatcher read port: returns the pending tag or the value, with commit-bus bypass.
module reg_rename_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_pos_type rs,
  input  logic        commit_flag,
  input  reg_pos_type rd_from_rob,
  input  rob_id_type  Q_from_rob,
  input  data_type    V_from_rob,
  input  rob_id_type  tag   [REG_NUM],
  input  data_type    value [REG_NUM],
  output rob_id_type  q,
  output data_type    v
);

  // NOTE: defaults first so every path assigns q and v, otherwise a latch is inferred.
  always_comb begin
    q = ZERO_ROB;
    v = ZERO_WORD;
    if (rs == ZERO_REG) begin
      q = ZERO_ROB;
      v = ZERO_WORD;
    end else if (commit_flag && rd_from_rob == rs && tag[rs] == Q_from_rob) begin
      // The value this register waits for is on the commit bus right now.
      v = V_from_rob;
    end else begin
      q = tag[rs];
      v = value[rs];
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags, fed by ROB commit and dispatch.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  reg_pos_type rs1_from_dsp,
  input  reg_pos_type rs2_from_dsp,
  output rob_id_type  Q1_to_dsp,
  output rob_id_type  Q2_to_dsp,
  output data_type    V1_to_dsp,
  output data_type    V2_to_dsp,
  input  logic        ena_from_dsp,
  input  reg_pos_type rd_from_dsp,
  input  rob_id_type  rob_id_from_dsp,
  input  logic        commit_flag,
  input  reg_pos_type rd_from_rob,
  input  rob_id_type  Q_from_rob,
  input  data_type    V_from_rob,
  input  logic        commit_jump_flag
);

  rob_id_type tag   [REG_NUM];
  data_type   value [REG_NUM];

  // NOTE: non-blocking assignments throughout; where several apply to the same tag
  // in one cycle the last one written wins, which encodes the priority
  // commit-clear < flush / rename.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset on purpose: reads must return 0 after reset.
      tag   <= '{default: ZERO_ROB};
      value <= '{default: ZERO_WORD};
    end else begin
      if (commit_flag && rd_from_rob != ZERO_REG) begin
        value[rd_from_rob] <= V_from_rob;
        if (tag[rd_from_rob] == Q_from_rob)
          tag[rd_from_rob] <= ZERO_ROB;
      end
      if (commit_jump_flag) begin
        tag <= '{default: ZERO_ROB};
      end else if (ena_from_dsp && rd_from_dsp != ZERO_REG) begin
        tag[rd_from_dsp] <= rob_id_from_dsp;
      end
    end
  end

  reg_rename_read_port u_read1 (
    .rs          (rs1_from_dsp),
    .commit_flag (commit_flag),
    .rd_from_rob (rd_from_rob),
    .Q_from_rob  (Q_from_rob),
    .V_from_rob  (V_from_rob),
    .tag         (tag),
    .value       (value),
    .q           (Q1_to_dsp),
    .v           (V1_to_dsp)
  );

  reg_rename_read_port u_read2 (
    .rs          (rs2_from_dsp),
    .commit_flag (commit_flag),
    .rd_from_rob (rd_from_rob),
    .Q_from_rob  (Q_from_rob),
    .V_from_rob  (V_from_rob),
    .tag         (tag),
    .value       (value),
    .q           (Q2_to_dsp),
    .v           (V2_to_dsp)
  );

  // Tag 0 means "no pending producer", so it can never name a renaming instruction.
  rename_id_nonzero: assert property (
    @(posedge clk) disable iff (rst) ena_from_dsp |-> rob_id_from_dsp != ZERO_ROB
  );

endmodule
